// File: rtl/md_sched.sv
// md_sched - multiply/divide scheduler and HI/LO owner for the 5-stage MIPS pipe.
//
// An md op issued from E (start pulse) latches its operands' result into a
// pending pair and stays busy for a fixed latency. The result is committed to
// HI/LO at the edge where the countdown reaches 1. mthi/mtlo write HI/LO
// directly while idle. stall_D holds D whenever a HI/LO user would collide
// with an op that is starting or still running.
//
// Ports:
//   clk, rst       clock (rising edge), async active-low reset
//   start, op      E-stage md op pulse; 0=mult 1=multu 2=div 3=divu
//   src_a, src_b   rs / rt operands (forwarded)
//   wr_hi, wr_lo   mthi / mtlo in E (write src_a)
//   md_use_D       D-stage instruction touches the md unit or HI/LO
//   busy           op pending (registered)
//   stall_D        freeze F/D, flush E (combinational)
//   hi, lo         architectural HI/LO
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state, state_nx;
    logic [3:0]  count;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_skip;
    logic        commit;

    // Result datapath, evaluated from the operands present at the start edge.
    logic signed [63:0] sa64, sb64, smul;
    logic        [63:0] umul;
    logic signed [32:0] sa33, sb33, squo, srem;
    logic        [31:0] udiv_b, uquo, urem;
    logic               div_zero;
    logic        [31:0] res_hi, res_lo;

    assign sa64 = {{32{src_a[31]}}, src_a};
    assign sb64 = {{32{src_b[31]}}, src_b};
    assign smul = sa64 * sb64;
    assign umul = {32'b0, src_a} * {32'b0, src_b};

    // Divide by zero commits nothing; substitute 1 so the dividers never see 0.
    // The 33-bit signed divide makes 0x80000000 / -1 yield 2^31, whose low
    // word is 0x80000000 with remainder 0.
    assign div_zero = (src_b == 32'd0);
    assign udiv_b   = div_zero ? 32'd1 : src_b;
    assign sa33     = {src_a[31], src_a};
    assign sb33     = {udiv_b[31], udiv_b};
    assign squo     = sa33 / sb33;
    assign srem     = sa33 % sb33;
    assign uquo     = src_a / udiv_b;
    assign urem     = src_a % udiv_b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            2'd0: begin res_hi = smul[63:32]; res_lo = smul[31:0]; end
            2'd1: begin res_hi = umul[63:32]; res_lo = umul[31:0]; end
            2'd2: begin res_hi = srem[31:0];  res_lo = squo[31:0]; end
            default: begin res_hi = urem;     res_lo = uquo;       end
        endcase
    end

    assign commit = (state == RUN) && (count == 4'd1);

    // FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)  state_nx = RUN;
            RUN:     if (commit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counter, pending result and HI/LO. A start seen in RUN is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= 4'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_skip <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else if (state == IDLE) begin
            if (start) begin
                count     <= op[1] ? DIV_N : MULT_N;
                pend_hi   <= res_hi;
                pend_lo   <= res_lo;
                pend_skip <= op[1] & div_zero;
            end else begin
                if (wr_hi) hi <= src_a;
                if (wr_lo) lo <= src_a;
            end
        end else begin
            count <= count - 4'd1;
            if (commit && !pend_skip) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

    assign busy    = (state == RUN);
    assign stall_D = md_use_D & (start | busy);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched - randomized bench for md_sched against a queue-free
// arithmetic reference model (remaining-cycle count + pending result).
module tb_md_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        wr_hi, wr_lo, md_use_D;
    logic        busy, stall_D;
    logic [31:0] hi, lo;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .md_use_D(md_use_D),
        .busy(busy), .stall_D(stall_D), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_skip;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl, output bit skip);
        int          sa, sb;
        longint      la, lb, q, r, p;
        longint unsigned up;
        logic [63:0] w;
        sa = a; sb = b;
        la = sa; lb = sb;
        skip = 0; rh = 0; rl = 0;
        case (o)
            2'd0: begin p = la * lb; w = p; rh = w[63:32]; rl = w[31:0]; end
            2'd1: begin up = longint'(a) * longint'(b); w = up; rh = w[63:32]; rl = w[31:0]; end
            2'd2: if (b == 0) skip = 1;
                  else begin q = la / lb; r = la % lb; w = q; rl = w[31:0]; w = r; rh = w[31:0]; end
            default: if (b == 0) skip = 1;
                  else begin rl = a / b; rh = a % b; end
        endcase
    endfunction

    function automatic int lat(input logic [1:0] o);
        return o[1] ? 10 : 5;
    endfunction

    // One clock cycle: drive, check stall, advance model, clock, check state.
    task automatic cyc(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic wh, input logic wl, input logic mu);
        start = s; op = o; src_a = a; src_b = b; wr_hi = wh; wr_lo = wl; md_use_D = mu;
        #1;
        last_stall = stall_D;
        chk("stall_D", {31'b0, stall_D}, {31'b0, mu & (s | (m_rem > 0))});
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && !p_skip) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (s) begin
            calc(o, a, b, p_hi, p_lo, p_skip);
            m_rem = lat(o);
        end else begin
            if (wh) m_hi = a;
            if (wl) m_lo = a;
        end
        @(posedge clk); #1;
        chk("busy", {31'b0, busy}, {31'b0, m_rem > 0});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic idle(input logic mu);
        cyc(1'b0, 2'd0, $urandom, $urandom, 1'b0, 1'b0, mu);
    endtask

    // Issue one op and wait for it to drain (model-bounded).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic mu);
        int guard = 0;
        cyc(1'b1, o, a, b, 1'b0, 1'b0, mu);
        while (m_rem > 0 && guard < 40) begin idle(mu); guard++; end
    endtask

    initial begin
        int nst;
        logic [31:0] rb;
        m_rem = 0; m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_skip = 0;
        rst = 1'b0; start = 0; op = 0; src_a = 0; src_b = 0; wr_hi = 0; wr_lo = 0; md_use_D = 0;
        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk); rst = 1'b1;

        // mult 3 * -2
        run_op(2'd0, 32'd3, 32'hFFFFFFFE, 1'b0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        // divu 7/2, div -7/2
        run_op(2'd3, 32'd7, 32'd2, 1'b0);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // stall window: start cycle + 10 busy cycles, none after commit
        nst = 0;
        cyc(1'b1, 2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1); nst += int'(last_stall);
        for (int i = 0; i < 10; i++) begin idle(1'b1); nst += int'(last_stall); end
        idle(1'b1); nst += int'(last_stall);
        chk("stall_cnt", nst, 32'd11);
        chk("stall_after", {31'b0, last_stall}, 32'd0);

        // mtlo, then divide by zero keeps HI/LO
        cyc(1'b0, 2'd0, 32'h12345678, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("mtlo_lo", lo, 32'h12345678);
        chk("mtlo_hi", hi, 32'd2);
        run_op(2'd2, 32'd55, 32'd0, 1'b0);
        chk("div0_lo", lo, 32'h12345678);
        chk("div0_hi", hi, 32'd2);

        // overflow case
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);

        // start during RUN is ignored
        cyc(1'b1, 2'd0, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b1, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        chk("viol_lo", lo, 32'd6);
        chk("viol_busy", {31'b0, busy}, 32'd0);

        // async reset mid-mult (cycle 3)
        cyc(1'b1, 2'd0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0);
        #1 rst = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        m_rem = 0; m_hi = 0; m_lo = 0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 6; i++) idle(1'b0);
        chk("arst_nocommit", lo, 32'd0);
        run_op(2'd0, 32'd5, 32'd6, 1'b0);
        chk("after_rst_lo", lo, 32'd30);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic s;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            s = (m_rem == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            cyc(s, 2'($urandom_range(0, 3)), $urandom, rb,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler and HI/LO owner for the 5-stage MIPS pipeline.
- Accepts a mult/multu/div/divu issued from stage E and holds the operation busy for a fixed latency.
- Generates the stall for stage D when a HI/LO-using instruction would collide with a pending operation.
- Commits results to HI/LO and serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- start  input  1  E-stage md op valid this cycle; single-cycle pulse per instruction.
- op  input  2  0=mult, 1=multu, 2=div, 3=divu; sampled when start=1.
- src_a  input  32  rs operand (forwarded value from E).
- src_b  input  32  rt operand (forwarded value from E).
- wr_hi  input  1  mthi in E.
- wr_lo  input  1  mtlo in E.
- md_use_D  input  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation pending.
- stall_D  output  1  freeze F/D and flush E register this cycle.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter=0, busy=0, hi=0, lo=0, pending result cleared. Takes effect immediately, including mid-operation; the pending op is aborted and never committed.
- States:
  - IDLE: on clk edge with start=1, load pending {hi,lo} and counter = MULT_CYCLES or DIV_CYCLES per op[1]. Go to RUN.
  - RUN: each edge decrements counter. At the edge where counter==1, commit pending to hi/lo and return to IDLE.
- Timing: start sampled at edge T. busy=1 from after T through edge T+N, where N is the latency. hi/lo carry the new values from edge T+N onward, the same edge at which busy falls.
- busy is registered and equals (state==RUN).
- stall_D = md_use_D & (start | busy). This is combinational; no stall when md_use_D=0.
- Start while RUN: ignored. The stall_D protocol prevents it; the bench checks that state is unaffected.
- Arithmetic is computed from the operands sampled at the start edge:
  - mult: signed 64-bit product, {hi,lo}=a*b.
  - multu: unsigned 64-bit product.
  - div: lo=signed quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (src_b==0 with div/divu): still busy for DIV_CYCLES; hi/lo unchanged at commit.
- div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo:
  - In IDLE with start=0: wr_hi loads hi<=src_a and wr_lo loads lo<=src_a on the next edge; both may be asserted together.
  - In RUN, or coinciding with start: ignored (start has priority).
- hi/lo are readable at all times and show the last committed value while RUN.
- A back-to-back start at the commit edge is impossible (the op is stalled in D), so no simultaneous commit+start handling is required beyond start-in-RUN being ignored.

Test Plan:
- mult a=3, b=0xFFFFFFFE, start pulse -> busy=1 for 5 cycles; after the 5th edge hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- divu a=7, b=2 -> busy 10 cycles; then lo=3, hi=1. div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Hold md_use_D=1 during start and RUN -> stall_D=1 exactly on the start cycle plus every busy cycle; stall_D=0 on the cycle after commit. With md_use_D=0 -> stall_D stays 0.
- mtlo src_a=0x12345678 in IDLE -> lo=0x12345678, hi unchanged. div with b=0 -> 10 busy cycles, then hi/lo keep their prior values.
- Assert rst=0 asynchronously at cycle 3 of a mult -> busy, hi, lo drop to 0 without waiting for clk. After release, no commit occurs and a new start works normally.
- Pulse start with multu during RUN (stall protocol violated) -> counter and pending result are unaffected; the original op commits on schedule.
